// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer between branch predictor, icache and instruction buffer
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 8,
  parameter int          EXCP_W          = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       bp_pc,
  input  logic              bp_taken0,
  input  logic              bp_taken1,
  input  logic [31:0]       bp_target,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [31:0]       req_pc,
  output logic [1:0]        req_size,
  input  logic              resp_valid,
  input  logic [31:0]       resp_inst0,
  input  logic [31:0]       resp_inst1,
  input  logic              resp_have_excp,
  input  logic [EXCP_W-1:0] resp_excp_type,
  input  logic [3:0]        ibuf_length,
  output logic [1:0]        ibuf_i_size,
  output logic [31:0]       ibuf_i0_pc,
  output logic [31:0]       ibuf_i0_inst,
  output logic              ibuf_i0_pred_br_taken,
  output logic [31:0]       ibuf_i0_pred_br_target,
  output logic              ibuf_i0_have_excp,
  output logic [EXCP_W-1:0] ibuf_i0_excp_type,
  output logic [31:0]       ibuf_i1_pc,
  output logic [31:0]       ibuf_i1_inst,
  output logic              ibuf_i1_pred_br_taken,
  output logic [31:0]       ibuf_i1_pred_br_target
);

  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {ST_RUN, ST_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [2:0]  reserved_q, reserved_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW-1:0] wr_ptr_q, wr_ptr_d;

  // Request queue: one entry per accepted request, popped by in-order responses
  logic [31:0] q_pc_q     [MAX_OUTSTANDING];
  logic [1:0]  q_size_q   [MAX_OUTSTANDING];
  logic        q_t0_q     [MAX_OUTSTANDING];
  logic        q_t1_q     [MAX_OUTSTANDING];
  logic [31:0] q_target_q [MAX_OUTSTANDING];

  logic [1:0]  grp_size;
  logic [31:0] next_pc;
  logic        slot1_taken;
  logic [4:0]  inflight_w;
  logic [4:0]  need_w;
  logic        fire;
  logic        resp_live;
  logic        resp_drop;
  logic [31:0] hd_pc;
  logic [1:0]  hd_size;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Issue decision, prediction, response routing and next-state computation
  always_comb begin
    grp_size    = fetch_pc_q[2] ? 2'd1 : 2'd2;
    req_size    = bp_taken0 ? 2'd1 : grp_size;
    slot1_taken = !bp_taken0 && (grp_size == 2'd2) && bp_taken1;
    if (bp_taken0 || slot1_taken) begin
      next_pc = bp_target;
    end else begin
      next_pc = fetch_pc_q + {28'd0, req_size, 2'b00};
    end
    bp_pc  = fetch_pc_q;
    req_pc = fetch_pc_q;

    inflight_w = 5'(cnt_q) + 5'(drop_cnt_q);
    need_w     = 5'(ibuf_length) + 5'(reserved_q) + 5'(req_size);
    req_valid  = resetn && (state_q == ST_RUN) && !redirect_valid &&
                 (inflight_w < 5'(MAX_OUTSTANDING)) && (need_w <= 5'(IBUF_DEPTH));
    fire       = req_valid && req_ready;

    resp_live = resetn && resp_valid && !redirect_valid && (drop_cnt_q == 2'd0);
    resp_drop = resetn && resp_valid && !redirect_valid && (drop_cnt_q != 2'd0);

    hd_pc   = q_pc_q[rd_ptr_q];
    hd_size = q_size_q[rd_ptr_q];

    ibuf_i_size            = !resp_live ? 2'd0 : (resp_have_excp ? 2'd1 : hd_size);
    ibuf_i0_pc             = hd_pc;
    ibuf_i0_inst           = resp_inst0;
    ibuf_i0_pred_br_taken  = q_t0_q[rd_ptr_q];
    ibuf_i0_pred_br_target = q_target_q[rd_ptr_q];
    ibuf_i0_have_excp      = resp_live && resp_have_excp;
    ibuf_i0_excp_type      = resp_excp_type;
    ibuf_i1_pc             = hd_pc + 32'd4;
    ibuf_i1_inst           = resp_inst1;
    ibuf_i1_pred_br_taken  = q_t1_q[rd_ptr_q];
    ibuf_i1_pred_br_target = q_target_q[rd_ptr_q];

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    reserved_d = reserved_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      // Everything in flight becomes garbage; a response this cycle is one of them.
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
      drop_cnt_d = 2'(inflight_w - 5'(resp_valid));
      reserved_d = 3'd0;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = next_pc;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end
      if (resp_live) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (resp_have_excp) begin
          state_d = ST_HALT;
        end
      end
      cnt_d      = cnt_q + CW'(fire) - CW'(resp_live);
      reserved_d = reserved_q + (fire ? {1'b0, req_size} : 3'd0)
                              - (resp_live ? {1'b0, hd_size} : 3'd0);
    end
  end

  // State registers and queue entry write on request acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= 2'd0;
      reserved_q <= 3'd0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        q_pc_q[i]     <= '0;
        q_size_q[i]   <= '0;
        q_t0_q[i]     <= 1'b0;
        q_t1_q[i]     <= 1'b0;
        q_target_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      reserved_q <= reserved_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (fire) begin
        q_pc_q[wr_ptr_q]     <= fetch_pc_q;
        q_size_q[wr_ptr_q]   <= req_size;
        q_t0_q[wr_ptr_q]     <= bp_taken0;
        q_t1_q[wr_ptr_q]     <= slot1_taken;
        q_target_q[wr_ptr_q] <= bp_target;
      end
    end
  end

  // A response must always correspond to a live or to-be-dropped request
  resp_has_owner: assert property (@(posedge clk) disable iff (!resetn)
    resp_valid |-> ((cnt_q != '0) || (drop_cnt_q != 2'd0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] bp_pc;
  logic        bp_taken0, bp_taken1;
  logic [31:0] bp_target;
  logic        req_valid, req_ready;
  logic [31:0] req_pc;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_inst0, resp_inst1;
  logic        resp_have_excp;
  logic [4:0]  resp_excp_type;
  logic [3:0]  ibuf_length;
  logic [1:0]  ibuf_i_size;
  logic [31:0] ibuf_i0_pc, ibuf_i0_inst, ibuf_i0_pred_br_target;
  logic        ibuf_i0_pred_br_taken, ibuf_i0_have_excp;
  logic [4:0]  ibuf_i0_excp_type;
  logic [31:0] ibuf_i1_pc, ibuf_i1_inst, ibuf_i1_pred_br_target;
  logic        ibuf_i1_pred_br_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .bp_pc                  (bp_pc),
    .bp_taken0              (bp_taken0),
    .bp_taken1              (bp_taken1),
    .bp_target              (bp_target),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_pc                 (req_pc),
    .req_size               (req_size),
    .resp_valid             (resp_valid),
    .resp_inst0             (resp_inst0),
    .resp_inst1             (resp_inst1),
    .resp_have_excp         (resp_have_excp),
    .resp_excp_type         (resp_excp_type),
    .ibuf_length            (ibuf_length),
    .ibuf_i_size            (ibuf_i_size),
    .ibuf_i0_pc             (ibuf_i0_pc),
    .ibuf_i0_inst           (ibuf_i0_inst),
    .ibuf_i0_pred_br_taken  (ibuf_i0_pred_br_taken),
    .ibuf_i0_pred_br_target (ibuf_i0_pred_br_target),
    .ibuf_i0_have_excp      (ibuf_i0_have_excp),
    .ibuf_i0_excp_type      (ibuf_i0_excp_type),
    .ibuf_i1_pc             (ibuf_i1_pc),
    .ibuf_i1_inst           (ibuf_i1_inst),
    .ibuf_i1_pred_br_taken  (ibuf_i1_pred_br_taken),
    .ibuf_i1_pred_br_target (ibuf_i1_pred_br_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next drive point: falling edge, then let combinational outputs settle
  task automatic step_to_drive;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bp_taken0 = 1'b0; bp_taken1 = 1'b0; bp_target = '0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_inst0 = '0; resp_inst1 = '0;
    resp_have_excp = 1'b0; resp_excp_type = '0; ibuf_length = '0;

    // Reset state
    step_to_drive; #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_i_size", ibuf_i_size, 2'd0);
    chk("rst_bp_pc", bp_pc, 32'h1c000000);

    // Stream: first request right after reset release
    step_to_drive; resetn = 1'b1; #1;
    chk("a_req_valid", req_valid, 1'b1);
    chk("a_req_pc", req_pc, 32'h1c000000);
    chk("a_req_size", req_size, 2'd2);

    step_to_drive; resp_valid = 1'b1; resp_inst0 = 32'haaaa0000; resp_inst1 = 32'haaaa0001; #1;
    chk("b_i_size", ibuf_i_size, 2'd2);
    chk("b_i0_pc", ibuf_i0_pc, 32'h1c000000);
    chk("b_i1_pc", ibuf_i1_pc, 32'h1c000004);
    chk("b_i0_inst", ibuf_i0_inst, 32'haaaa0000);
    chk("b_i1_inst", ibuf_i1_inst, 32'haaaa0001);
    chk("b_req_pc", req_pc, 32'h1c000008);
    chk("b_req_valid", req_valid, 1'b1);

    step_to_drive; #1;
    chk("c_i0_pc", ibuf_i0_pc, 32'h1c000008);
    chk("c_i_size", ibuf_i_size, 2'd2);
    chk("c_req_pc", req_pc, 32'h1c000010);

    step_to_drive; req_ready = 1'b0; #1;
    chk("d_i0_pc", ibuf_i0_pc, 32'h1c000010);
    chk("d_req_pc", req_pc, 32'h1c000018);

    // Redirect to an unaligned address
    step_to_drive; resp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c000004; #1;
    chk("e_redir_req_valid", req_valid, 1'b0);
    chk("e_redir_i_size", ibuf_i_size, 2'd0);

    step_to_drive; redirect_valid = 1'b0; req_ready = 1'b1; #1;
    chk("f_req_valid", req_valid, 1'b1);
    chk("f_req_pc", req_pc, 32'h1c000004);
    chk("f_req_size", req_size, 2'd1);

    // Slot-1 predicted taken
    step_to_drive; bp_taken1 = 1'b1; bp_target = 32'h1c000100;
    resp_valid = 1'b1; resp_inst0 = 32'hbbbb0000; #1;
    chk("g_i_size", ibuf_i_size, 2'd1);
    chk("g_i0_pc", ibuf_i0_pc, 32'h1c000004);
    chk("g_req_pc", req_pc, 32'h1c000008);
    chk("g_req_size", req_size, 2'd2);

    step_to_drive; bp_taken1 = 1'b0; req_ready = 1'b0; #1;
    chk("h_i_size", ibuf_i_size, 2'd2);
    chk("h_i0_taken", ibuf_i0_pred_br_taken, 1'b0);
    chk("h_i1_taken", ibuf_i1_pred_br_taken, 1'b1);
    chk("h_i1_target", ibuf_i1_pred_br_target, 32'h1c000100);
    chk("h_bp_pc", bp_pc, 32'h1c000100);

    // Backpressure: 7 + 2 exceeds depth
    step_to_drive; resp_valid = 1'b0; ibuf_length = 4'd7; #1;
    chk("i_full_size2", req_valid, 1'b0);

    step_to_drive; redirect_valid = 1'b1; redirect_pc = 32'h1c000104; #1;
    step_to_drive; redirect_valid = 1'b0; req_ready = 1'b1; #1;
    chk("j_req_valid", req_valid, 1'b1);
    chk("j_req_size", req_size, 2'd1);
    chk("j_req_pc", req_pc, 32'h1c000104);

    step_to_drive; resp_valid = 1'b1; resp_inst0 = 32'hdddd0000; #1;
    chk("k_reserved_block", req_valid, 1'b0);
    chk("k_i_size", ibuf_i_size, 2'd1);
    chk("k_i0_pc", ibuf_i0_pc, 32'h1c000104);

    step_to_drive; resp_valid = 1'b0; ibuf_length = 4'd8; #1;
    for (int i = 0; i < 4; i++) begin
      chk("l_full_hold", req_valid, 1'b0);
      step_to_drive; #1;
    end

    // Exactly at depth with size 2, and stability under !req_ready
    ibuf_length = 4'd6; req_ready = 1'b0; #1;
    chk("m_req_valid", req_valid, 1'b1);
    chk("m_req_size", req_size, 2'd2);
    chk("m_req_pc", req_pc, 32'h1c000108);
    step_to_drive; #1;
    chk("m2_req_pc_stable", req_pc, 32'h1c000108);
    chk("m2_req_valid", req_valid, 1'b1);

    // Two requests in flight, then redirect
    step_to_drive; ibuf_length = 4'd0; req_ready = 1'b1; #1;
    chk("n_req_pc", req_pc, 32'h1c000108);
    step_to_drive; #1;
    chk("o_req_pc", req_pc, 32'h1c000110);
    step_to_drive; #1;
    chk("o2_max_out", req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h1c002000;
    resp_valid = 1'b1; resp_inst0 = 32'heeee0000; #1;
    chk("p_i_size", ibuf_i_size, 2'd0);
    chk("p_req_valid", req_valid, 1'b0);

    step_to_drive; redirect_valid = 1'b0; #1;
    chk("q_drop_i_size", ibuf_i_size, 2'd0);
    chk("q_req_valid", req_valid, 1'b1);
    chk("q_req_pc", req_pc, 32'h1c002000);

    step_to_drive; resp_inst0 = 32'hcccc0000; req_ready = 1'b0; #1;
    chk("r_i_size", ibuf_i_size, 2'd2);
    chk("r_i0_pc", ibuf_i0_pc, 32'h1c002000);
    chk("r_i0_inst", ibuf_i0_inst, 32'hcccc0000);

    // Fetch exception halts issue
    step_to_drive; resp_valid = 1'b0; req_ready = 1'b1; #1;
    chk("s_req_pc", req_pc, 32'h1c002008);
    step_to_drive; resp_valid = 1'b1; resp_have_excp = 1'b1; resp_excp_type = 5'h0d; req_ready = 1'b0; #1;
    chk("t_i_size", ibuf_i_size, 2'd1);
    chk("t_have_excp", ibuf_i0_have_excp, 1'b1);
    chk("t_excp_type", ibuf_i0_excp_type, 5'h0d);
    step_to_drive; resp_valid = 1'b0; resp_have_excp = 1'b0; req_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("u_halt", req_valid, 1'b0);
      chk("u_no_excp", ibuf_i0_have_excp, 1'b0);
      step_to_drive; #1;
    end

    redirect_valid = 1'b1; redirect_pc = 32'h1c003000; #1;
    chk("v_req_valid", req_valid, 1'b0);
    step_to_drive; redirect_valid = 1'b0; #1;
    chk("w_req_valid", req_valid, 1'b1);
    chk("w_req_pc", req_pc, 32'h1c003000);
    step_to_drive; #1;
    chk("x_req_pc", req_pc, 32'h1c003008);

    // Async reset with two outstanding
    step_to_drive; resetn = 1'b0; #1;
    chk("y_rst_req_valid", req_valid, 1'b0);
    chk("y_rst_bp_pc", bp_pc, 32'h1c000000);
    step_to_drive; resetn = 1'b1; #1;
    chk("z_req_valid", req_valid, 1'b1);
    chk("z_req_pc", req_pc, 32'h1c000000);
    chk("z_req_size", req_size, 2'd2);
    chk("z_i_size", ibuf_i_size, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
